// File: rtl/ddr_avl_pattern_checker_if.sv
// Avalon-MM local-port bundle between the pattern checker (master) and the
// DDR2 UniPHY controller (slave).
interface ddr_avl_pattern_checker_if #(
  parameter int unsigned ADDR_W = 24,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned SIZE_W = 2
);
  logic              avl_ready;
  logic              avl_burstbegin;
  logic [ADDR_W-1:0] avl_addr;
  logic [SIZE_W-1:0] avl_size;
  logic              avl_write_req;
  logic [DATA_W-1:0] avl_wdata;
  logic              avl_read_req;
  logic              avl_rdata_valid;
  logic [DATA_W-1:0] avl_rdata;

  modport master (
    input  avl_ready, avl_rdata_valid, avl_rdata,
    output avl_burstbegin, avl_addr, avl_size, avl_write_req, avl_wdata, avl_read_req
  );

  modport slave (
    output avl_ready, avl_rdata_valid, avl_rdata,
    input  avl_burstbegin, avl_addr, avl_size, avl_write_req, avl_wdata, avl_read_req
  );
endinterface

// File: rtl/ddr_avl_pattern_checker.sv
// DDR2 self-test engine: writes a generated pattern in bursts, reads it back with
// several bursts outstanding and checks every beat against a regenerated copy.
module ddr_avl_pattern_checker #(
  parameter int unsigned ADDR_W     = 24,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned SIZE_W     = 2,
  parameter int unsigned BURST_LEN  = 2,
  parameter int unsigned NUM_BURSTS = 16,
  parameter int unsigned MAX_RD_OUT = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              local_init_done,
  input  logic              local_cal_success,
  input  logic              local_cal_fail,
  ddr_avl_pattern_checker_if.master bus,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              cal_fail,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr
);

  localparam int unsigned N     = NUM_BURSTS * BURST_LEN;
  localparam int unsigned IDX_W = $clog2(N + 1);
  localparam int unsigned BW    = $clog2(NUM_BURSTS + 1);
  localparam int unsigned OW    = $clog2(MAX_RD_OUT + 1);

  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0]  ALL_IDX    = IDX_W'(N);
  localparam logic [BW-1:0]     ALL_BURSTS = BW'(NUM_BURSTS);
  localparam logic [OW-1:0]     MAX_OUT    = OW'(MAX_RD_OUT);
  localparam logic [SIZE_W-1:0] BURST_SIZE = SIZE_W'(BURST_LEN);
  localparam logic [SIZE_W-1:0] LAST_BEAT  = SIZE_W'(BURST_LEN - 1);
  localparam logic [ADDR_W-1:0] ADDR_STEP  = ADDR_W'(BURST_LEN);
  localparam logic [31:0]       SEED       = 32'hACE1_0001;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_CAL, S_WRITE, S_READ, S_DONE, S_FAILCAL
  } state_t;

  state_t state, next;

  logic [1:0]        mode_r;
  logic [ADDR_W-1:0] base_r;
  logic [ADDR_W-1:0] burst_addr;
  logic [SIZE_W-1:0] wr_beat, rd_beat;
  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic [31:0]       wr_lfsr, rd_lfsr;
  logic [BW-1:0]     rd_bursts;
  logic [OW-1:0]     outstanding;
  logic              chk_valid;
  logic [DATA_W-1:0] chk_data, chk_exp;
  logic [ADDR_W-1:0] chk_addr;

  logic wr_acc, rd_issue, rd_acc, ret_acc, ret_last;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  function automatic logic [DATA_W-1:0] pattern(input logic [1:0] m, input logic [ADDR_W-1:0] a,
                                                input logic [IDX_W-1:0] i, input logic [31:0] lf);
    logic [31:0]       a32;
    logic [DATA_W-1:0] one, res;
    a32    = 32'(a);
    one    = '0;
    one[0] = 1'b1;
    unique case (m)
      2'd0:    res = {(DATA_W/32){a32}};
      2'd1:    res = one << (32'(i) % DATA_W);
      2'd2:    res = {(DATA_W/32){lf}};
      default: res = ~{(DATA_W/32){a32}};
    endcase
    return res;
  endfunction

  assign wr_acc   = (state == S_WRITE) && bus.avl_ready;
  assign rd_issue = (state == S_READ) && (rd_bursts < ALL_BURSTS) && (outstanding < MAX_OUT);
  assign rd_acc   = rd_issue && bus.avl_ready;
  // Returns are only meaningful while reads are owed; stray valids are dropped.
  assign ret_acc  = (state == S_READ) && bus.avl_rdata_valid && (outstanding != '0);
  assign ret_last = ret_acc && (rd_beat == LAST_BEAT);

  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= next;
  end

  always_comb begin
    next               = state;
    busy               = 1'b0;
    bus.avl_write_req  = 1'b0;
    bus.avl_read_req   = 1'b0;
    bus.avl_burstbegin = 1'b0;
    bus.avl_addr       = burst_addr;
    bus.avl_size       = BURST_SIZE;
    bus.avl_wdata      = '0;
    unique case (state)
      S_IDLE, S_DONE, S_FAILCAL: next = start ? S_WAIT_CAL : S_IDLE;
      S_WAIT_CAL: begin
        busy = 1'b1;
        if (local_cal_fail)                             next = S_FAILCAL;
        else if (local_init_done && local_cal_success)  next = S_WRITE;
      end
      S_WRITE: begin
        busy               = 1'b1;
        bus.avl_write_req  = 1'b1;
        bus.avl_burstbegin = (wr_beat == '0);
        bus.avl_wdata      = pattern(mode_r, base_r + ADDR_W'(wr_idx), wr_idx, wr_lfsr);
        if (wr_acc && wr_idx == LAST_IDX) next = S_READ;
      end
      S_READ: begin
        busy               = 1'b1;
        bus.avl_read_req   = rd_issue;
        bus.avl_burstbegin = rd_issue;
        // Wait for the compare stage to drain so err_count is final at DONE.
        if (rd_bursts == ALL_BURSTS && rd_idx == ALL_IDX && !chk_valid) next = S_DONE;
      end
      default: next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      mode_r         <= '0;
      base_r         <= '0;
      burst_addr     <= '0;
      wr_beat        <= '0;
      rd_beat        <= '0;
      wr_idx         <= '0;
      rd_idx         <= '0;
      wr_lfsr        <= '0;
      rd_lfsr        <= '0;
      rd_bursts      <= '0;
      outstanding    <= '0;
      chk_valid      <= 1'b0;
      chk_data       <= '0;
      chk_exp        <= '0;
      chk_addr       <= '0;
      done           <= 1'b0;
      pass           <= 1'b0;
      cal_fail       <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else begin
      chk_valid <= 1'b0;
      if (start && !busy) begin
        mode_r         <= mode;
        base_r         <= base_addr;
        burst_addr     <= base_addr;
        wr_beat        <= '0;
        rd_beat        <= '0;
        wr_idx         <= '0;
        rd_idx         <= '0;
        wr_lfsr        <= SEED;
        rd_lfsr        <= SEED;
        rd_bursts      <= '0;
        outstanding    <= '0;
        done           <= 1'b0;
        pass           <= 1'b0;
        cal_fail       <= 1'b0;
        err_count      <= '0;
        first_err_addr <= '0;
      end
      if (state == S_WAIT_CAL && local_cal_fail) begin
        done     <= 1'b1;
        cal_fail <= 1'b1;
      end
      if (wr_acc) begin
        wr_idx  <= wr_idx + 1'b1;
        wr_lfsr <= lfsr_step(wr_lfsr);
        if (wr_beat == LAST_BEAT) begin
          wr_beat    <= '0;
          burst_addr <= burst_addr + ADDR_STEP;
        end else begin
          wr_beat <= wr_beat + 1'b1;
        end
        if (wr_idx == LAST_IDX) burst_addr <= base_r;
      end
      if (rd_acc) begin
        burst_addr <= burst_addr + ADDR_STEP;
        rd_bursts  <= rd_bursts + 1'b1;
      end
      if (ret_acc) begin
        rd_idx    <= rd_idx + 1'b1;
        rd_lfsr   <= lfsr_step(rd_lfsr);
        rd_beat   <= (rd_beat == LAST_BEAT) ? '0 : rd_beat + 1'b1;
        chk_valid <= 1'b1;
        chk_data  <= bus.avl_rdata;
        chk_exp   <= pattern(mode_r, base_r + ADDR_W'(rd_idx), rd_idx, rd_lfsr);
        chk_addr  <= base_r + ADDR_W'(rd_idx);
      end
      if (rd_acc && !ret_last)      outstanding <= outstanding + 1'b1;
      else if (!rd_acc && ret_last) outstanding <= outstanding - 1'b1;
      if (chk_valid && chk_data != chk_exp) begin
        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        if (err_count == 16'h0)    first_err_addr <= chk_addr;
      end
      if (state == S_READ && next == S_DONE) begin
        done <= 1'b1;
        pass <= (err_count == 16'h0);
      end
    end
  end

endmodule

// File: tb/tb_ddr_avl_pattern_checker.sv
// Scoreboard bench for ddr_avl_pattern_checker: a memory BFM answers the Avalon
// port while a monitor pops expected writes, reads and final status per pass.
module tb_ddr_avl_pattern_checker;
  localparam int unsigned ADDR_W     = 24;
  localparam int unsigned DATA_W     = 64;
  localparam int unsigned SIZE_W     = 2;
  localparam int unsigned BURST_LEN  = 2;
  localparam int unsigned NUM_BURSTS = 16;
  localparam int unsigned MAX_RD_OUT = 4;
  localparam int unsigned N          = NUM_BURSTS * BURST_LEN;

  logic              CLK = 1'b0;
  logic              RST;
  logic              start;
  logic [1:0]        mode;
  logic [ADDR_W-1:0] base_addr;
  logic              local_init_done, local_cal_success, local_cal_fail;
  logic              busy, done, pass, cal_fail;
  logic [15:0]       err_count;
  logic [ADDR_W-1:0] first_err_addr;

  ddr_avl_pattern_checker_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SIZE_W(SIZE_W)) bus ();

  ddr_avl_pattern_checker #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SIZE_W(SIZE_W),
    .BURST_LEN(BURST_LEN), .NUM_BURSTS(NUM_BURSTS), .MAX_RD_OUT(MAX_RD_OUT)
  ) u_dut (
    .CLK(CLK), .RST(RST), .start(start), .mode(mode), .base_addr(base_addr),
    .local_init_done(local_init_done), .local_cal_success(local_cal_success),
    .local_cal_fail(local_cal_fail), .bus(bus), .busy(busy), .done(done), .pass(pass),
    .cal_fail(cal_fail), .err_count(err_count), .first_err_addr(first_err_addr)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              bb;
  } wr_t;
  typedef struct {
    logic              pass;
    logic              cal_fail;
    logic [15:0]       err;
    logic [ADDR_W-1:0] first;
  } st_t;
  typedef struct {
    logic [ADDR_W-1:0] addr;
    int unsigned       due;
  } rd_t;

  wr_t               exp_wr[$];
  logic [ADDR_W-1:0] exp_rd[$];
  st_t               exp_st[$];

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  function automatic logic [DATA_W-1:0] model_word(input logic [1:0] m, input logic [ADDR_W-1:0] b,
                                                   input int unsigned i);
    logic [ADDR_W-1:0] wa;
    logic [31:0]       a, lf;
    logic [DATA_W-1:0] w;
    wa = b + ADDR_W'(i);
    a  = 32'(wa);
    lf = 32'hACE1_0001;
    for (int unsigned s = 0; s < i; s++) lf = {lf[30:0], lf[31] ^ lf[21] ^ lf[1] ^ lf[0]};
    case (m)
      2'd0:    w = {a, a};
      2'd1:    begin w = '0; w[i % DATA_W] = 1'b1; end
      2'd2:    w = {lf, lf};
      default: w = ~{a, a};
    endcase
    return w;
  endfunction

  // Memory BFM
  logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];
  rd_t               rd_q[$];
  int unsigned       cyc = 0, ret_beat = 0, inflight = 0, wr_beat = 0, lat = 3;
  logic              rand_ready = 1'b0, fault_en = 1'b0;
  logic [ADDR_W-1:0] fault_addr = 24'd7;

  always @(negedge CLK) begin
    logic              last_presented;
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] d;
    cyc++;
    last_presented = 1'b0;
    if (RST) begin
      rd_q.delete();
      inflight            = 0;
      ret_beat            = 0;
      wr_beat             = 0;
      bus.avl_ready       = 1'b0;
      bus.avl_rdata_valid = 1'b0;
      bus.avl_rdata       = '0;
    end else begin
      bus.avl_ready       = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.avl_rdata_valid = 1'b0;
      if (rd_q.size() != 0 && rd_q[0].due <= cyc) begin
        ra = rd_q[0].addr + ADDR_W'(ret_beat);
        d  = mem.exists(ra) ? mem[ra] : '0;
        if (fault_en && ra == fault_addr) d[5] = ~d[5];
        bus.avl_rdata_valid = 1'b1;
        bus.avl_rdata       = d;
        if (ret_beat == BURST_LEN - 1) begin
          ret_beat = 0;
          void'(rd_q.pop_front());
          last_presented = 1'b1;
        end else begin
          ret_beat++;
        end
      end
      #1;
      if (bus.avl_write_req && bus.avl_ready) begin
        if (bus.avl_burstbegin) wr_beat = 0;
        mem[bus.avl_addr + ADDR_W'(wr_beat)] = bus.avl_wdata;
        wr_beat++;
      end
      if (bus.avl_read_req && bus.avl_ready) begin
        check("outstanding_limit", 64'(inflight < MAX_RD_OUT), 64'd1);
        rd_q.push_back('{bus.avl_addr, cyc + lat});
        inflight++;
      end
      if (last_presented) inflight--;
    end
  end

  // Monitor
  logic done_prev = 1'b0;
  always @(negedge CLK) begin
    wr_t               e;
    st_t               s;
    logic [ADDR_W-1:0] a;
    #1;
    if (!RST) begin
      if (bus.avl_write_req && bus.avl_ready) begin
        if (exp_wr.size() == 0) check("unexpected_write", 64'(bus.avl_write_req), 64'd0);
        else begin
          e = exp_wr.pop_front();
          check("wr_addr", 64'(bus.avl_addr), 64'(e.addr));
          check("wr_data", bus.avl_wdata, e.data);
          check("wr_burstbegin", 64'(bus.avl_burstbegin), 64'(e.bb));
          check("wr_size", 64'(bus.avl_size), 64'(BURST_LEN));
        end
      end
      if (bus.avl_read_req && bus.avl_ready) begin
        if (exp_rd.size() == 0) check("unexpected_read", 64'(bus.avl_read_req), 64'd0);
        else begin
          a = exp_rd.pop_front();
          check("rd_addr", 64'(bus.avl_addr), 64'(a));
          check("rd_burstbegin", 64'(bus.avl_burstbegin), 64'd1);
          check("rd_size", 64'(bus.avl_size), 64'(BURST_LEN));
        end
      end
      if (done && !done_prev) begin
        if (exp_st.size() == 0) check("unexpected_done", 64'(done), 64'd0);
        else begin
          s = exp_st.pop_front();
          check("st_busy", 64'(busy), 64'd0);
          check("st_pass", 64'(pass), 64'(s.pass));
          check("st_cal_fail", 64'(cal_fail), 64'(s.cal_fail));
          check("st_err_count", 64'(err_count), 64'(s.err));
          check("st_first_err_addr", 64'(first_err_addr), 64'(s.first));
        end
      end
    end
    done_prev = done;
  end

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic expect_pass(input logic [1:0] m, input logic [ADDR_W-1:0] b, input logic fault);
    for (int unsigned k = 0; k < NUM_BURSTS; k++) begin
      for (int unsigned j = 0; j < BURST_LEN; j++)
        exp_wr.push_back('{b + ADDR_W'(k * BURST_LEN), model_word(m, b, k * BURST_LEN + j), j == 0});
      exp_rd.push_back(b + ADDR_W'(k * BURST_LEN));
    end
    exp_st.push_back('{!fault, 1'b0, fault ? 16'd1 : 16'd0, fault ? b + ADDR_W'(7) : '0});
  endtask

  task automatic kick(input logic [1:0] m, input logic [ADDR_W-1:0] b);
    mode      = m;
    base_addr = b;
    start     = 1'b1;
    step();
    start     = 1'b0;
    mode      = 2'd0;
    base_addr = '0;
  endtask

  task automatic wait_done(input int unsigned budget);
    int unsigned n = 0;
    while (!done && n < budget) begin
      step();
      n++;
    end
    check("done_seen", 64'(done), 64'd1);
    repeat (6) step();
    check("wr_queue_drained", 64'(exp_wr.size()), 64'd0);
    check("rd_queue_drained", 64'(exp_rd.size()), 64'd0);
    check("status_queue_drained", 64'(exp_st.size()), 64'd0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_pass"}, 64'(pass), 64'd0);
    check({tag, "_cal_fail"}, 64'(cal_fail), 64'd0);
    check({tag, "_err_count"}, 64'(err_count), 64'd0);
    check({tag, "_first_err_addr"}, 64'(first_err_addr), 64'd0);
    check({tag, "_write_req"}, 64'(bus.avl_write_req), 64'd0);
    check({tag, "_read_req"}, 64'(bus.avl_read_req), 64'd0);
    check({tag, "_burstbegin"}, 64'(bus.avl_burstbegin), 64'd0);
  endtask

  initial begin
    int unsigned n;
    RST = 1'b1; start = 1'b0; mode = '0; base_addr = '0;
    local_init_done = 1'b1; local_cal_success = 1'b1; local_cal_fail = 1'b0;
    repeat (4) step();
    RST = 1'b0;
    step();
    check_idle("reset");

    // T1: mode0, base 0, always ready
    expect_pass(2'd0, 24'd0, 1'b0);
    kick(2'd0, 24'd0);
    wait_done(3000);

    // T2: corrupted bit 5 on word 7
    fault_en = 1'b1;
    expect_pass(2'd0, 24'd0, 1'b1);
    kick(2'd0, 24'd0);
    wait_done(3000);
    fault_en = 1'b0;

    // T3: random stalls, long read latency
    rand_ready = 1'b1;
    lat        = 20;
    expect_pass(2'd1, 24'd100, 1'b0);
    kick(2'd1, 24'd100);
    wait_done(5000);
    rand_ready = 1'b0;
    lat        = 3;

    // T4: calibration failure, no Avalon traffic expected
    local_cal_success = 1'b0;
    local_cal_fail    = 1'b1;
    exp_st.push_back('{1'b0, 1'b1, 16'd0, '0});
    kick(2'd0, 24'd0);
    wait_done(100);
    local_cal_success = 1'b1;
    local_cal_fail    = 1'b0;

    // T5: LFSR pattern across the address wrap
    expect_pass(2'd2, 24'hFFFFFC, 1'b0);
    kick(2'd2, 24'hFFFFFC);
    wait_done(3000);

    // T6: reset mid-read, then a clean pass
    expect_pass(2'd3, 24'd40, 1'b0);
    kick(2'd3, 24'd40);
    n = 0;
    while (exp_rd.size() > NUM_BURSTS - 3 && n < 3000) begin
      step();
      n++;
    end
    check("t6_read_started", 64'(exp_rd.size() <= NUM_BURSTS - 3), 64'd1);
    RST = 1'b1;
    exp_wr.delete();
    exp_rd.delete();
    exp_st.delete();
    repeat (3) step();
    RST = 1'b0;
    step();
    check_idle("mid_reset");
    repeat (25) step();
    check("stale_returns_ignored", 64'(busy), 64'd0);
    expect_pass(2'd3, 24'd40, 1'b0);
    kick(2'd3, 24'd40);
    wait_done(3000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
